// File: rtl/pixel_mem_pkg.sv
// Shared constants and types for the pixel memory port A arbiter.
package pixel_mem_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  typedef logic [0:0] req_id_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/pixel_mem_port_arbiter_rd_tag_pipe.sv
// Fixed-depth shift register of {valid, id} tags that tracks reads in flight
// until their data arrives on q_a. A reset empties every stage.
module pixel_mem_port_arbiter_rd_tag_pipe
  import pixel_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid,
  input  req_id_t in_id,
  output logic    out_valid,
  output req_id_t out_id
);

  logic    valid_reg  [DEPTH];
  req_id_t id_reg     [DEPTH];
  logic    valid_next [DEPTH];
  req_id_t id_next    [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign valid_next[gi] = in_valid;
      assign id_next[gi]    = in_id;
    end else begin : g_body
      assign valid_next[gi] = valid_reg[gi-1];
      assign id_next[gi]    = id_reg[gi-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg[gi] <= 1'b0;
        id_reg[gi]    <= '0;
      end else begin
        valid_reg[gi] <= valid_next[gi];
        id_reg[gi]    <= id_next[gi];
      end
    end
  end

  assign out_valid = valid_reg[DEPTH-1];
  assign out_id    = id_reg[DEPTH-1];

endmodule

// File: rtl/pixel_mem_port_arbiter.sv
// Two-requester arbiter for pixel memory port A: round-robin with burst locking,
// drives the memory select/address/data/wren and steers q_a back to the reader.
module pixel_mem_port_arbiter #(
  parameter int ADDR_W     = pixel_mem_pkg::ADDR_W,
  parameter int DATA_W     = pixel_mem_pkg::DATA_W,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_i,
  input  logic [1:0]        lock_i,
  input  logic [1:0]        we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_select,
  output logic [ADDR_W-1:0] mem_addr_a_1,
  output logic [ADDR_W-1:0] mem_addr_a_2,
  output logic [DATA_W-1:0] mem_data_a,
  output logic              mem_wren_a,
  input  logic [DATA_W-1:0] mem_q_a
);

  import pixel_mem_pkg::*;

  arb_state_t state_reg, state_next;
  req_id_t    prio_reg, prio_next;  // requester that wins a tie in IDLE
  req_id_t    sel_reg, sel_next;    // last winner, held while nobody is granted
  req_id_t    win_id;
  logic [1:0] gnt;
  logic       any_gnt;

  logic       tag_valid;
  req_id_t    tag_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      prio_reg  <= 1'b0;
      sel_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      prio_reg  <= prio_next;
      sel_reg   <= sel_next;
    end
  end

  always_comb begin
    gnt        = 2'b00;
    win_id     = prio_reg;
    state_next = state_reg;
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          if (req_i == 2'b11)  win_id = prio_reg;
          else if (req_i[0])   win_id = 1'b0;
          else                 win_id = 1'b1;
          if (req_i != 2'b00) begin
            gnt[win_id] = 1'b1;
            if (lock_i[win_id]) state_next = win_id ? OWN1 : OWN0;
          end
        end
        OWN0: begin
          win_id = 1'b0;
          gnt[0] = req_i[0];
          // Releasing the lock still lets a final access through this cycle.
          if (!lock_i[0]) state_next = IDLE;
        end
        OWN1: begin
          win_id = 1'b1;
          gnt[1] = req_i[1];
          if (!lock_i[1]) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    any_gnt   = |gnt;
    prio_next = prio_reg;
    sel_next  = sel_reg;
    if (any_gnt) begin
      prio_next = ~win_id;
      sel_next  = win_id;
    end
  end

  assign gnt_o        = gnt;
  assign mem_select   = rst ? 1'b0 : (any_gnt ? win_id : sel_reg);
  assign mem_addr_a_1 = addr0_i;
  assign mem_addr_a_2 = addr1_i;
  assign mem_data_a   = mem_select ? wdata1_i : wdata0_i;
  assign mem_wren_a   = any_gnt & we_i[win_id];

  pixel_mem_port_arbiter_rd_tag_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (any_gnt & ~we_i[win_id]),
    .in_id     (win_id),
    .out_valid (tag_valid),
    .out_id    (tag_id)
  );

  // Tags still in the pipe during a reset cycle belong to discarded reads.
  assign rvalid_o = (tag_valid && !rst) ? (2'b01 << tag_id) : 2'b00;
  assign rdata_o  = mem_q_a;

endmodule

// File: tb/tb_pixel_mem_port_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a transaction-level model.
module tb_pixel_mem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req, lock, we;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    gnt, rvalid;
  logic [DW-1:0] rdata;
  logic          mem_select, mem_wren_a;
  logic [AW-1:0] mem_addr_a_1, mem_addr_a_2;
  logic [DW-1:0] mem_data_a, mem_q_a;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pixel_mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req_i(req), .lock_i(lock), .we_i(we),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .mem_select(mem_select), .mem_addr_a_1(mem_addr_a_1), .mem_addr_a_2(mem_addr_a_2),
    .mem_data_a(mem_data_a), .mem_wren_a(mem_wren_a), .mem_q_a(mem_q_a)
  );

  // Stand-in for pixel_memory_sel port A: registered address, registered output.
  // Reset restores the preload image (0xA5 at 0x005, zero elsewhere).
  logic [DW-1:0] tb_mem [1024];
  logic [DW-1:0] rd_stage;
  logic [AW-1:0] tb_addr;
  assign tb_addr = mem_select ? mem_addr_a_2 : mem_addr_a_1;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) tb_mem[i] <= (i == 5) ? 8'hA5 : 8'h00;
    end else if (mem_wren_a) begin
      tb_mem[tb_addr] <= mem_data_a;
    end
    rd_stage <= tb_mem[tb_addr];
    mem_q_a  <= rd_stage;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    int          id;
    logic [7:0]  data;
  } rd_t;

  rd_t        rq[$];
  logic [7:0] mmem [1024];
  int         m_owner = -1;
  int         m_fav = 0;
  int         m_sel = 0;
  int         m_cyc = 0;

  always @(negedge clk) begin
    int         win;
    logic [1:0] eg, erv;
    logic [7:0] erd;
    logic [9:0] a;
    logic       ewr;
    logic [7:0] ed;
    win = -1; eg = 2'b00; erv = 2'b00; erd = 8'h00;
    if (!rst) begin
      if (m_owner >= 0) begin
        if (req[m_owner]) win = m_owner;
      end else if (req == 2'b11) win = m_fav;
      else if (req[0]) win = 0;
      else if (req[1]) win = 1;
      if (win >= 0) eg[win] = 1'b1;
      if (rq.size() > 0 && rq[0].due == m_cyc) begin
        erv[rq[0].id] = 1'b1;
        erd = rq[0].data;
      end
    end
    ewr = (win >= 0) && we[win];
    ed  = (win == 1) ? wdata1 : wdata0;
    chk("model_gnt", {30'd0, gnt}, {30'd0, eg});
    chk("model_wren", {31'd0, mem_wren_a}, {31'd0, ewr});
    chk("model_select", {31'd0, mem_select},
        rst ? 32'd0 : ((win >= 0) ? win : m_sel));
    if (ewr) chk("model_wdata", {24'd0, mem_data_a}, {24'd0, ed});
    chk("model_rvalid", {30'd0, rvalid}, {30'd0, erv});
    if (erv != 2'b00) chk("model_rdata", {24'd0, rdata}, {24'd0, erd});

    if (rst) begin
      m_owner = -1; m_fav = 0; m_sel = 0;
      rq.delete();
      for (int i = 0; i < 1024; i++) mmem[i] = (i == 5) ? 8'hA5 : 8'h00;
    end else begin
      if (rq.size() > 0 && rq[0].due == m_cyc) void'(rq.pop_front());
      if (m_owner >= 0) begin
        if (!lock[m_owner]) m_owner = -1;
      end else if (win >= 0 && lock[win]) m_owner = win;
      if (win >= 0) begin
        m_fav = 1 - win;
        m_sel = win;
        a = (win == 1) ? addr1 : addr0;
        if (we[win]) mmem[a] = ed;
        else rq.push_back('{due: m_cyc + RD_LAT, id: win, data: mmem[a]});
      end
    end
    m_cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    req = r; lock = l; we = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
  endtask

  logic          pend [2];
  logic          p_we [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_data [2];
  logic [1:0]    gnt_last;

  initial begin
    rst = 1'b1;
    drive(2'b11, 2'b00, 2'b11, 10'h000, 10'h000, 8'h00, 8'h00);

    // Reset holds off every grant regardless of requests.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_gnt", {30'd0, gnt}, 32'd0);
      chk("reset_wren", {31'd0, mem_wren_a}, 32'd0);
      chk("reset_rvalid", {30'd0, rvalid}, 32'd0);
    end
    next_cycle;
    rst = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00);
    @(negedge clk);
    chk("post_reset_select", {31'd0, mem_select}, 32'd0);

    // Single read by requester 1 of the preloaded location.
    next_cycle;
    drive(2'b10, 2'b00, 2'b00, 10'h000, 10'h005, 8'h00, 8'h00);
    @(negedge clk);
    chk("rd1_gnt", {30'd0, gnt}, 32'h2);
    chk("rd1_select", {31'd0, mem_select}, 32'd1);
    next_cycle;
    drive(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00);
    @(negedge clk);
    chk("rd1_rvalid_early", {30'd0, rvalid}, 32'd0);
    next_cycle;
    @(negedge clk);
    chk("rd1_rvalid", {30'd0, rvalid}, 32'h2);
    chk("rd1_rdata", {24'd0, rdata}, 32'hA5);
    next_cycle;
    @(negedge clk);
    chk("rd1_rvalid_after", {30'd0, rvalid}, 32'd0);

    // Both requesting without lock: strict alternation, returns in grant order.
    for (int i = 0; i < 8; i++) begin
      next_cycle;
      if (i < 6) drive(2'b11, 2'b00, 2'b00, 10'(i), 10'(i + 32), 8'h00, 8'h00);
      else       drive(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00);
      @(negedge clk);
      if (i < 6) chk("rr_gnt", {30'd0, gnt}, (i % 2) ? 32'h2 : 32'h1);
      if (i >= 2) chk("rr_rvalid", {30'd0, rvalid}, ((i - 2) % 2) ? 32'h2 : 32'h1);
    end

    // Locked write burst by requester 0 while requester 1 waits to read.
    for (int i = 0; i < 5; i++) begin
      next_cycle;
      if (i < 4) drive(2'b11, (i < 3) ? 2'b01 : 2'b00, 2'b01, 10'(i), 10'h007,
                       8'(8'h10 + i), 8'h00);
      else       drive(2'b10, 2'b00, 2'b00, 10'h000, 10'h007, 8'h00, 8'h00);
      @(negedge clk);
      if (i < 4) begin
        chk("burst_gnt", {30'd0, gnt}, 32'h1);
        chk("burst_wren", {31'd0, mem_wren_a}, 32'd1);
      end else begin
        chk("burst_next_gnt", {30'd0, gnt}, 32'h2);
      end
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle;
      drive(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00);
    end

    // Write then immediate read of the same address returns the new value.
    next_cycle;
    drive(2'b01, 2'b00, 2'b01, 10'h100, 10'h000, 8'h3C, 8'h00);
    @(negedge clk);
    chk("wr_gnt", {30'd0, gnt}, 32'h1);
    next_cycle;
    drive(2'b01, 2'b00, 2'b00, 10'h100, 10'h000, 8'h00, 8'h00);
    @(negedge clk);
    chk("rd_gnt", {30'd0, gnt}, 32'h1);
    next_cycle;
    drive(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00);
    next_cycle;
    @(negedge clk);
    chk("wr_rd_rvalid", {30'd0, rvalid}, 32'h1);
    chk("wr_rd_rdata", {24'd0, rdata}, 32'h3C);

    // Reset right after a read grant discards the read.
    next_cycle;
    drive(2'b10, 2'b00, 2'b00, 10'h000, 10'h005, 8'h00, 8'h00);
    @(negedge clk);
    chk("rst_rd_gnt", {30'd0, gnt}, 32'h2);
    next_cycle;
    rst = 1'b1;
    drive(2'b11, 2'b11, 2'b00, 10'h000, 10'h005, 8'h00, 8'h00);
    @(negedge clk);
    chk("rst_mid_gnt", {30'd0, gnt}, 32'd0);
    next_cycle;
    rst = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00);
    @(negedge clk);
    chk("rst_mid_rvalid", {30'd0, rvalid}, 32'd0);
    next_cycle;
    @(negedge clk);
    chk("rst_mid_rvalid2", {30'd0, rvalid}, 32'd0);

    // Randomized traffic; each requester holds its transaction until granted.
    for (int n = 0; n < 2; n++) begin
      pend[n] = 1'b0; p_we[n] = 1'b0; p_addr[n] = '0; p_data[n] = '0;
    end
    gnt_last = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      next_cycle;
      for (int n = 0; n < 2; n++) begin
        if (pend[n] && gnt_last[n]) pend[n] = 1'b0;
        if (!pend[n] && $urandom_range(0, 99) < 65) begin
          pend[n]   = 1'b1;
          p_we[n]   = 1'($urandom_range(0, 1));
          p_addr[n] = 10'($urandom_range(0, 15));
          p_data[n] = 8'($urandom);
        end
      end
      rst = ($urandom_range(0, 299) == 0);
      drive({pend[1], pend[0]}, 2'($urandom_range(0, 3)), {p_we[1], p_we[0]},
            p_addr[0], p_addr[1], p_data[0], p_data[1]);
      @(negedge clk);
      gnt_last = gnt;
    end

    next_cycle;
    rst = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00);
    repeat (6) next_cycle;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
